instruction_fetch: RTL and testbench

- Fetch stage of the CPU core.
- Drives the address of the combinational program_memory and registers the returned 16-bit word into an instruction register for decode.
- Owns the program counter (PC). Handles in-order increment, redirects from execute (jump/branch), pipeline stalls, and halt on the null instruction 16'hFFFF.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/program_counter.sv | 28 ++
 rtl/instruction_fetch.sv | 100 ++++++++++
 tb/tb_instruction_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, the null instruction and fetch states.
package cpu_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] NULL_INSTR = 16'hFFFF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/program_counter.sv
// Program counter register. A load takes priority over an increment, and the
// increment wraps modulo 2^ADDR_WIDTH.
module program_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // PC update: reset, then redirect load, then sequential increment.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge values; blocking = here would make ordering between blocks matter.
    if (rst) begin
      pc <= ADDR_WIDTH'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule : program_counter

// File: rtl/instruction_fetch.sv
// Fetch stage: addresses program memory from the PC, captures the returned
// word into the instruction register, and handles redirects, stalls and halt.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  input  logic [INSTR_WIDTH-1:0] pm_data,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  output logic                   halted
);

  fetch_state_t          state, state_next;
  logic                  pc_load, pc_inc, ir_load;
  logic                  valid_next, halted_next;
  logic [ADDR_WIDTH-1:0] pc;

  program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_val(jump_addr),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // Memory address comes straight from the PC register, never from jump_addr.
  assign pm_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and control decode; jump beats stall, stall beats null detection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next  = state;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    valid_next  = instr_valid;
    halted_next = halted;
    unique case (state)
      FETCH: begin
        if (jump_en) begin
          pc_load    = 1'b1;
          valid_next = 1'b0;
        end else if (stall) begin
          valid_next = instr_valid;
        end else if (pm_data == NULL_INSTR) begin
          state_next  = HALT;
          halted_next = 1'b1;
          valid_next  = 1'b0;
        end else begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          valid_next = 1'b1;
        end
      end
      HALT: begin
        valid_next  = 1'b0;
        halted_next = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Instruction register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (ir_load) begin
        instr    <= pm_data;
        instr_pc <= pc;
      end
      instr_valid <= valid_next;
      halted      <= halted_next;
    end
  end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instruction_fetch;

  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_data;
  logic          stall = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;

  logic [15:0] mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int          m_pc, m_ipc;
  logic [15:0] m_ir;
  bit          m_valid, m_halted, m_ready;

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .pm_addr    (pm_addr),
    .pm_data    (pm_data),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  // Combinational program memory
  assign pm_data = mem[pm_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the fetch rules once per rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_ir = 16'h0000; m_ipc = 0;
      m_valid = 1'b0; m_halted = 1'b0; m_ready = 1'b1;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (jump_en) begin
      m_pc = int'(jump_addr); m_valid = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (mem[m_pc] == 16'hFFFF) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else begin
      m_ir = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
      m_pc = (m_pc + 1) % DEPTH;
    end
  end

  // Compare process: DUT against model on every falling edge once reset is seen.
  always @(negedge clk) begin
    if (m_ready) begin
      check("model_pm_addr", 16'(pm_addr), 16'(m_pc));
      check("model_instr", instr, m_ir);
      check("model_instr_pc", 16'(instr_pc), 16'(m_ipc));
      check("model_valid", 16'(instr_valid), 16'(m_valid));
      check("model_halted", 16'(halted), 16'(m_halted));
    end
  end

  // Advance one rising edge, then settle inputs just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge for literal checks.
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'hFFFF) mem[i] = 16'h0000;
    end
    mem[0]   = 16'hA203;
    mem[1]   = 16'hA305;
    mem[255] = 16'hFFFF;

    // Reset edge
    step();
    sample();
    check("rst_pm_addr", 16'(pm_addr), 16'h0000);
    check("rst_valid", 16'(instr_valid), 16'h0);
    check("rst_instr", instr, 16'h0000);
    check("rst_halted", 16'(halted), 16'h0);
    rst = 1'b0;

    // First fetch edge
    step();
    sample();
    check("seq0_instr", instr, 16'hA203);
    check("seq0_pc", 16'(instr_pc), 16'h0000);
    check("seq0_valid", 16'(instr_valid), 16'h1);
    check("seq0_pm_addr", 16'(pm_addr), 16'h0001);

    // Stall for three edges
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      check("stall_instr", instr, 16'hA203);
      check("stall_valid", 16'(instr_valid), 16'h1);
      check("stall_pm_addr", 16'(pm_addr), 16'h0001);
    end
    step();
    stall = 1'b0;
    step();
    sample();
    check("seq1_instr", instr, 16'hA305);
    check("seq1_pc", 16'(instr_pc), 16'h0001);
    check("seq1_pm_addr", 16'(pm_addr), 16'h0002);

    // Jump back to 0 while pc=2
    jump_en = 1'b1; jump_addr = 8'h00;
    step();
    jump_en = 1'b0;
    sample();
    check("jmp_valid", 16'(instr_valid), 16'h0);
    check("jmp_pm_addr", 16'(pm_addr), 16'h0000);
    check("jmp_instr_hold", instr, 16'hA305);
    step();
    sample();
    check("jmp_tgt_instr", instr, 16'hA203);
    check("jmp_tgt_pc", 16'(instr_pc), 16'h0000);
    check("jmp_tgt_valid", 16'(instr_valid), 16'h1);

    // Jump and stall together: jump wins
    jump_en = 1'b1; stall = 1'b1; jump_addr = 8'h01;
    step();
    jump_en = 1'b0; stall = 1'b0;
    sample();
    check("jmpstall_pm_addr", 16'(pm_addr), 16'h0001);
    check("jmpstall_valid", 16'(instr_valid), 16'h0);
    step();
    sample();
    check("jmpstall_instr", instr, 16'hA305);

    // Jump to the null word at the top address
    jump_en = 1'b1; jump_addr = 8'hFF;
    step();
    jump_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      sample();
      check("halt_halted", 16'(halted), 16'h1);
      check("halt_valid", 16'(instr_valid), 16'h0);
      check("halt_pm_addr", 16'(pm_addr), 16'h00FF);
      check("halt_instr", instr, 16'hA305);
      jump_en = ~jump_en; jump_addr = 8'h00; stall = (i % 3 == 0);
      @(posedge clk); #1;
    end
    jump_en = 1'b0; stall = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check("halt_rst_pm_addr", 16'(pm_addr), 16'h0000);
    check("halt_rst_halted", 16'(halted), 16'h0);

    // PC wrap with a non-null word at the top address
    mem[255] = 16'h1234;
    jump_en = 1'b1; jump_addr = 8'hFF;
    step();
    jump_en = 1'b0;
    step();
    sample();
    check("wrap_instr", instr, 16'h1234);
    check("wrap_pc", 16'(instr_pc), 16'h00FF);
    check("wrap_pm_addr", 16'(pm_addr), 16'h0000);
    step();
    sample();
    check("wrap_next_instr", instr, 16'hA203);

    // Reset during a stall with a live instruction
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    sample();
    check("midrst_valid", 16'(instr_valid), 16'h0);
    check("midrst_instr", instr, 16'h0000);
    check("midrst_pm_addr", 16'(pm_addr), 16'h0000);
    rst = 1'b0; stall = 1'b0;

    // Stall held on a null word: halt only once the stall releases
    mem[5] = 16'hFFFF;
    jump_en = 1'b1; jump_addr = 8'h05;
    step();
    jump_en = 1'b0; stall = 1'b1;
    step();
    step();
    sample();
    check("nullstall_halted", 16'(halted), 16'h0);
    stall = 1'b0;
    step();
    sample();
    check("nullstall_release", 16'(halted), 16'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Randomized traffic checked by the model, with a couple more null words
    mem[77]  = 16'hFFFF;
    mem[200] = 16'hFFFF;
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 9) < 3);
      jump_en   = ($urandom_range(0, 9) == 0);
      jump_addr = AW'($urandom);
      rst       = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; stall = 1'b0; jump_en = 1'b0;
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_instruction_fetch
